// File: rtl/fetch_stage.sv
// fetch_stage: 3-wide fetch with taken-branch truncation feeding a circular fetch queue.
// Optional performance counters are compiled in with `define FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     FQ_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 squash,
  input  logic [XLEN-1:0]      squash_pc,
  output logic [2:0]           fetch_EN,
  output logic [2:0][XLEN-1:0] fetch_pc,
  input  logic [2:0]           predict_found,
  input  logic [2:0]           predict_direction,
  input  logic [2:0][XLEN-1:0] predict_pc,
  input  logic [2:0]           icache_valid,
  input  logic [2:0][XLEN-1:0] icache_inst,
  output logic [2:0]           fq_valid,
  output logic [2:0][XLEN-1:0] fq_pc,
  output logic [2:0][XLEN-1:0] fq_inst,
  output logic [2:0]           fq_pred_taken,
  output logic [2:0][XLEN-1:0] fq_pred_target,
  input  logic [1:0]           dispatch_num
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0]          perf_fetched,
  output logic [63:0]          perf_redirects,
  output logic [63:0]          perf_fq_full_cycles
`endif
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } fq_entry_t;

  logic [XLEN-1:0]  pc_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  fq_entry_t        fq_mem [FQ_DEPTH];

  logic [CNT_W-1:0] free_c;
  logic [2:0]       slot_en_c;
  logic [2:0]       hit_c;
  logic [2:0]       keep_c;
  logic             taken_found_c;
  logic [XLEN-1:0]  taken_target_c;
  logic [1:0]       n_keep_c;
  logic [1:0]       deq_c;
  logic [XLEN-1:0]  pc_next_c;
  fq_entry_t        wr_entry_c [3];

  assign free_c = CNT_W'(FQ_DEPTH) - count_q;

  // Slot PCs are sequential from the held PC, slot 2 oldest
  assign fetch_pc[2] = pc_q;
  assign fetch_pc[1] = pc_q + XLEN'(4);
  assign fetch_pc[0] = pc_q + XLEN'(8);
  assign fetch_EN    = slot_en_c;

  // Enable the longest icache-hit prefix that fits in the space free at cycle start
  always_comb begin
    slot_en_c = '0;
    if (!reset && !squash) begin
      slot_en_c[2] = icache_valid[2] && (free_c >= CNT_W'(1));
      slot_en_c[1] = slot_en_c[2] && icache_valid[1] && (free_c >= CNT_W'(2));
      slot_en_c[0] = slot_en_c[1] && icache_valid[0] && (free_c >= CNT_W'(3));
    end
  end

  // Truncate at the oldest predicted-taken slot, pick the next PC and dequeue amount
  always_comb begin
    hit_c          = slot_en_c & predict_found & predict_direction;
    keep_c         = slot_en_c;
    taken_found_c  = 1'b0;
    taken_target_c = '0;
    if (hit_c[2]) begin
      keep_c         = 3'b100;
      taken_found_c  = 1'b1;
      taken_target_c = predict_pc[2];
    end else if (hit_c[1]) begin
      keep_c         = 3'b110;
      taken_found_c  = 1'b1;
      taken_target_c = predict_pc[1];
    end else if (hit_c[0]) begin
      keep_c         = 3'b111;
      taken_found_c  = 1'b1;
      taken_target_c = predict_pc[0];
    end
    n_keep_c  = 2'(keep_c[2]) + 2'(keep_c[1]) + 2'(keep_c[0]);
    pc_next_c = taken_found_c ? taken_target_c : pc_q + XLEN'({n_keep_c, 2'b00});
    deq_c     = (count_q < CNT_W'(dispatch_num)) ? 2'(count_q) : dispatch_num;
  end

  // Per-slot queue payloads; only the truncating slot carries a prediction
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      wr_entry_c[k].pc          = fetch_pc[k];
      wr_entry_c[k].inst        = icache_inst[k];
      wr_entry_c[k].pred_taken  = hit_c[k] & keep_c[k];
      wr_entry_c[k].pred_target = (hit_c[k] & keep_c[k]) ? predict_pc[k] : '0;
    end
  end

  // PC and queue pointers; squash flushes and redirects, reset overrides all
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (squash) begin
      pc_q    <= squash_pc;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_next_c;
      head_q  <= head_q + PTR_W'(deq_c);
      tail_q  <= tail_q + PTR_W'(n_keep_c);
      count_q <= count_q + CNT_W'(n_keep_c) - CNT_W'(deq_c);
    end
  end

  // Kept slots are written oldest-first starting at the tail
  always_ff @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (keep_c[k]) fq_mem[tail_q + PTR_W'(2 - k)] <= wr_entry_c[k];
    end
  end

  // Head window of the queue from registered state only; empty slots read as zero
  always_comb begin
    fq_valid       = '0;
    fq_pc          = '0;
    fq_inst        = '0;
    fq_pred_taken  = '0;
    fq_pred_target = '0;
    for (int i = 0; i < 3; i++) begin
      if (CNT_W'(i) < count_q) begin
        fq_valid[2-i]       = 1'b1;
        fq_pc[2-i]          = fq_mem[head_q + PTR_W'(i)].pc;
        fq_inst[2-i]        = fq_mem[head_q + PTR_W'(i)].inst;
        fq_pred_taken[2-i]  = fq_mem[head_q + PTR_W'(i)].pred_taken;
        fq_pred_target[2-i] = fq_mem[head_q + PTR_W'(i)].pred_target;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Cumulative counters; cleared only by reset, squash leaves them running
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched        <= '0;
      perf_redirects      <= '0;
      perf_fq_full_cycles <= '0;
    end else begin
      perf_fetched        <= perf_fetched + 64'(n_keep_c);
      perf_redirects      <= perf_redirects + 64'(taken_found_c);
      perf_fq_full_cycles <= perf_fq_full_cycles + 64'(count_q == CNT_W'(FQ_DEPTH));
    end
  end
`else
  // Performance counters not built in this configuration
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed checks of fetch_stage against a queue-based model.
// Build with `define FETCH_PERF_CNT_EN to also check the performance counters.
module tb_fetch_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] RPC   = 32'h100;

  logic                 clock;
  logic                 reset;
  logic                 squash;
  logic [XLEN-1:0]      squash_pc;
  logic [2:0]           fetch_EN;
  logic [2:0][XLEN-1:0] fetch_pc;
  logic [2:0]           predict_found;
  logic [2:0]           predict_direction;
  logic [2:0][XLEN-1:0] predict_pc;
  logic [2:0]           icache_valid;
  logic [2:0][XLEN-1:0] icache_inst;
  logic [2:0]           fq_valid;
  logic [2:0][XLEN-1:0] fq_pc;
  logic [2:0][XLEN-1:0] fq_inst;
  logic [2:0]           fq_pred_taken;
  logic [2:0][XLEN-1:0] fq_pred_target;
  logic [1:0]           dispatch_num;
`ifdef FETCH_PERF_CNT_EN
  logic [63:0]          perf_fetched;
  logic [63:0]          perf_redirects;
  logic [63:0]          perf_fq_full_cycles;
`endif

  fetch_stage #(.XLEN(XLEN), .FQ_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clock            (clock),
    .reset            (reset),
    .squash           (squash),
    .squash_pc        (squash_pc),
    .fetch_EN         (fetch_EN),
    .fetch_pc         (fetch_pc),
    .predict_found    (predict_found),
    .predict_direction(predict_direction),
    .predict_pc       (predict_pc),
    .icache_valid     (icache_valid),
    .icache_inst      (icache_inst),
    .fq_valid         (fq_valid),
    .fq_pc            (fq_pc),
    .fq_inst          (fq_inst),
    .fq_pred_taken    (fq_pred_taken),
    .fq_pred_target   (fq_pred_target),
    .dispatch_num     (dispatch_num)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched       (perf_fetched),
    .perf_redirects     (perf_redirects),
    .perf_fq_full_cycles(perf_fq_full_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        tk;
    logic [31:0] tgt;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  longint      m_fetched, m_redirects, m_full;
  int          n_vec, n_err;

  // Count a comparison and report any difference
  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Compare the queue head window against the model queue
  task automatic check_fq();
    logic [2:0]       ev, et;
    logic [2:0][31:0] ep, ei, eg;
    ev = '0; et = '0; ep = '0; ei = '0; eg = '0;
    for (int i = 0; i < 3; i++) begin
      if (i < q.size()) begin
        ev[2-i] = 1'b1;
        ep[2-i] = q[i].pc;
        ei[2-i] = q[i].inst;
        et[2-i] = q[i].tk;
        eg[2-i] = q[i].tgt;
      end
    end
    check("fq_valid", 128'(fq_valid), 128'(ev));
    check("fq_pc", 128'(fq_pc), 128'(ep));
    check("fq_inst", 128'(fq_inst), 128'(ei));
    check("fq_pred_taken", 128'(fq_pred_taken), 128'(et));
    check("fq_pred_target", 128'(fq_pred_target), 128'(eg));
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", 128'(perf_fetched), 128'(m_fetched));
    check("perf_redirects", 128'(perf_redirects), 128'(m_redirects));
    check("perf_fq_full_cycles", 128'(perf_fq_full_cycles), 128'(m_full));
`endif
  endtask

  // One clock cycle: drive inputs, check fetch outputs, advance model, check queue
  task automatic step(input bit rst, input bit sq, input logic [31:0] sqpc,
                      input logic [2:0] icv, input logic [2:0] pf, input logic [2:0] pd,
                      input logic [1:0] dn, input logic [31:0] tgt);
    logic [2:0]       exp_en;
    logic [2:0][31:0] ppc, inst, efpc;
    int               m, fr, d;
    bit               taken, full_now;
    int               kept;
    ent_t             e;
    for (int k = 0; k < 3; k++) begin
      ppc[k]  = (tgt != 0) ? tgt : ($urandom & 32'hffff_fffc);
      inst[k] = $urandom;
    end
    reset = rst; squash = sq; squash_pc = sqpc; icache_valid = icv;
    predict_found = pf; predict_direction = pd; predict_pc = ppc;
    icache_inst = inst; dispatch_num = dn;
    #1;
    fr = int'(DEPTH) - q.size();
    m = 0;
    if (!rst && !sq) begin
      for (int j = 0; j < 3; j++) begin
        if (m == j && icv[2-j] && (j + 1) <= fr) m++;
      end
    end
    exp_en = '0;
    for (int j = 0; j < m; j++) exp_en[2-j] = 1'b1;
    efpc[2] = m_pc; efpc[1] = m_pc + 32'd4; efpc[0] = m_pc + 32'd8;
    check("fetch_EN", 128'(fetch_EN), 128'(exp_en));
    check("fetch_pc", 128'(fetch_pc), 128'(efpc));
    full_now = (q.size() == int'(DEPTH));
    if (rst) begin
      q.delete();
      m_pc = RPC;
      m_fetched = 0; m_redirects = 0; m_full = 0;
    end else begin
      if (full_now) m_full++;
      if (sq) begin
        q.delete();
        m_pc = sqpc;
      end else begin
        d = (int'(dn) < q.size()) ? int'(dn) : q.size();
        repeat (d) void'(q.pop_front());
        taken = 0; kept = 0;
        for (int j = 0; j < m && !taken; j++) begin
          e.pc = m_pc + 32'(4 * j);
          e.inst = inst[2-j];
          e.tk = pf[2-j] & pd[2-j];
          e.tgt = e.tk ? ppc[2-j] : 32'd0;
          q.push_back(e);
          kept++;
          if (e.tk) begin
            taken = 1;
            m_pc = ppc[2-j];
          end
        end
        if (!taken) m_pc = m_pc + 32'(4 * kept);
        m_fetched += kept;
        if (taken) m_redirects++;
      end
    end
    @(posedge clock);
    #1;
    check_fq();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_pc = RPC; m_fetched = 0; m_redirects = 0; m_full = 0;
    reset = 1'b1; squash = 1'b0; squash_pc = '0; icache_valid = '0;
    predict_found = '0; predict_direction = '0; predict_pc = '0;
    icache_inst = '0; dispatch_num = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset fetch_EN", 128'(fetch_EN), 128'(0));
    check("reset fetch_pc2", 128'(fetch_pc[2]), 128'(32'h100));
    check_fq();

    // Sequential fetch from the reset PC
    step(0, 0, 0, 3'b111, 3'b000, 3'b000, 2'd0, 0);
    check("first fq_pc2", 128'(fq_pc[2]), 128'(32'h100));
    check("first fq_valid", 128'(fq_valid), 128'(3'b111));

    // Taken prediction in slot 1 at PC 0x200
    step(0, 1, 32'h200, 3'b111, 3'b000, 3'b000, 2'd0, 0);
    step(0, 0, 0, 3'b111, 3'b110, 3'b010, 2'd0, 32'h400);
    check("taken fq_valid", 128'(fq_valid), 128'(3'b110));
    check("taken flag", 128'(fq_pred_taken), 128'(3'b010));
    check("taken target", 128'(fq_pred_target[1]), 128'(32'h400));
    check("taken next pc", 128'(fetch_pc[2]), 128'(32'h400));

    // Fill to full, stall, then drain three and resume
    repeat (5) step(0, 0, 0, 3'b111, 3'b000, 3'b000, 2'd0, 0);
    step(0, 0, 0, 3'b111, 3'b000, 3'b000, 2'd3, 0);
    step(0, 0, 0, 3'b111, 3'b000, 3'b000, 2'd0, 0);

    // Non-prefix icache hit keeps only the oldest slot
    step(0, 1, 32'h300, 3'b111, 3'b000, 3'b000, 2'd0, 0);
    step(0, 0, 0, 3'b101, 3'b000, 3'b000, 2'd0, 0);
    check("prefix fq_valid", 128'(fq_valid), 128'(3'b100));

    // Squash with pending dispatch, then refetch from the target
    step(0, 0, 0, 3'b111, 3'b000, 3'b000, 2'd0, 0);
    step(0, 0, 0, 3'b011, 3'b000, 3'b000, 2'd0, 0);
    step(0, 1, 32'h80, 3'b111, 3'b000, 3'b000, 2'd2, 0);
    check("squash fq_valid", 128'(fq_valid), 128'(0));
    step(0, 0, 0, 3'b111, 3'b000, 3'b000, 2'd1, 0);
    check("post squash pc", 128'(fq_pc[2]), 128'(32'h80));

    // Randomized traffic
    for (int t = 0; t < 600; t++) begin
      logic [2:0] icv;
      for (int b = 0; b < 3; b++) icv[b] = ($urandom % 5) != 0;
      step(($urandom % 150) == 0, ($urandom % 16) == 0, $urandom & 32'hffff_fffc,
           icv, 3'($urandom), 3'($urandom), 2'($urandom), 0);
    end

    // Reset overrides a simultaneous squash
    step(1, 1, 32'h900, 3'b111, 3'b000, 3'b000, 2'd0, 0);
    check("reset over squash", 128'(fetch_pc[2]), 128'(32'h100));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
